// File: rtl/minsoc_clock_reset_sequencer_if.sv
// Bundle of the sequencer's external reset input, clock-manager handshake and status outputs.
// Signal suffixes are from the sequencer's point of view.
interface minsoc_clock_reset_sequencer_if;
  logic       ext_rst_i;
  logic       pll_locked_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic       lock_lost_o;
  logic [2:0] retries_o;
  logic [2:0] state_o;

  modport slave (
    input  ext_rst_i, pll_locked_i,
    output pll_rst_o, sys_rst_o, ready_o, fault_o, lock_lost_o, retries_o, state_o
  );

  modport master (
    output ext_rst_i, pll_locked_i,
    input  pll_rst_o, sys_rst_o, ready_o, fault_o, lock_lost_o, retries_o, state_o
  );
endinterface

// File: rtl/minsoc_clock_reset_sequencer.sv
// Clock-manager bring-up sequencer: pulses the clock manager reset, waits for lock with
// timeout/retry, requires a stable-lock window, then releases system reset.
module minsoc_clock_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  minsoc_clock_reset_sequencer_if.slave       seq_if
);

  localparam int unsigned CNT_MAX0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > STABLE_CYCLES) ? CNT_MAX0 : STABLE_CYCLES;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RW       = ($clog2(MAX_RETRIES) > 3) ? $clog2(MAX_RETRIES) : 3;

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LAST  = RW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   ext_s;
  logic                   lock_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retries_q, retries_d;
  logic             lock_lost_d;
  logic [2:0]       retries_sat_d;

  logic       pll_rst_q;
  logic       sys_rst_q;
  logic       ready_q;
  logic       fault_q;
  logic       lock_lost_q;
  logic [2:0] retries_o_q;
  logic [2:0] state_o_q;

  assign ext_s  = ext_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous button and LOCKED inputs into clk_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], seq_if.ext_rst_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], seq_if.pll_locked_i};
    end
  end

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    lock_lost_d = 1'b0;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d = '0;
          if (retries_q == RETRY_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d   = ST_PLL_RST;
            retries_d = retries_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (ext_s) begin
          cnt_d = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_PLL_RST;
          cnt_d       = '0;
          retries_d   = '0;
          lock_lost_d = 1'b1;
        end else if (ext_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (ext_s) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          retries_d = '0;
        end
      end
      default: begin
        state_d   = ST_PLL_RST;
        cnt_d     = '0;
        retries_d = '0;
      end
    endcase
    retries_sat_d = (retries_d > RW'(7)) ? 3'd7 : retries_d[2:0];
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retries_o_q <= '0;
      state_o_q   <= ST_PLL_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      sys_rst_q   <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
      lock_lost_q <= lock_lost_d;
      retries_o_q <= retries_sat_d;
      state_o_q   <= state_d;
    end
  end

  assign seq_if.pll_rst_o   = pll_rst_q;
  assign seq_if.sys_rst_o   = sys_rst_q;
  assign seq_if.ready_o     = ready_q;
  assign seq_if.fault_o     = fault_q;
  assign seq_if.lock_lost_o = lock_lost_q;
  assign seq_if.retries_o   = retries_o_q;
  assign seq_if.state_o     = state_o_q;

endmodule

// File: tb/tb_minsoc_clock_reset_sequencer.sv
// Directed bench for minsoc_clock_reset_sequencer. Inputs change 1ns after a rising edge,
// so an input set "after edge k" is first sampled by the synchroniser at edge k+1 and
// seen by the state machine at edge k+3.
module tb_minsoc_clock_reset_sequencer;

  localparam int unsigned PRC = 4;
  localparam int unsigned LT  = 32;
  localparam int unsigned SC  = 16;
  localparam int unsigned MR  = 3;
  localparam int unsigned SS  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  minsoc_clock_reset_sequencer_if sif ();

  minsoc_clock_reset_sequencer #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MR),
    .SYNC_STAGES    (SS)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .seq_if (sif)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic pr, input logic sr,
                          input logic rdy, input logic flt, input logic ll, input logic [2:0] rt);
    chk({tag, ".state"},     32'(sif.state_o),     32'(st));
    chk({tag, ".pll_rst"},   32'(sif.pll_rst_o),   32'(pr));
    chk({tag, ".sys_rst"},   32'(sif.sys_rst_o),   32'(sr));
    chk({tag, ".ready"},     32'(sif.ready_o),     32'(rdy));
    chk({tag, ".fault"},     32'(sif.fault_o),     32'(flt));
    chk({tag, ".lock_lost"}, 32'(sif.lock_lost_o), 32'(ll));
    chk({tag, ".retries"},   32'(sif.retries_o),   32'(rt));
  endtask

  // System reset must never be released while the clock manager is held in reset.
  always @(negedge clk_i) begin
    checks++;
    assert (!(sif.pll_rst_o && !sif.sys_rst_o)) else begin
      errors++;
      $error("FAIL invariant observed pll_rst=%0d sys_rst=%0d expected no pll_rst=1 with sys_rst=0",
             sif.pll_rst_o, sif.sys_rst_o);
    end
  end

  initial begin
    sif.ext_rst_i    = 1'b0;
    sif.pll_locked_i = 1'b0;

    // Reset values.
    tick(3);
    chk_outs("reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0;  // last reset edge is edge 0

    // 1: bring-up, lock 10 cycles after pll_rst_o falls.
    tick(3);                                                      // edge 3
    chk_outs("t1_prst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();                                                       // edge 4
    chk_outs("t1_wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(9);                                                      // edge 13
    chk("t1_wait13.state", 32'(sif.state_o), 32'd1);
    sif.pll_locked_i = 1'b1;                                      // rises before edge 14
    tick(2);                                                      // edge 15
    chk("t1_sync.state", 32'(sif.state_o), 32'd1);
    tick();                                                       // edge 16
    chk("t1_stable.state", 32'(sif.state_o), 32'd2);
    tick(15);                                                     // edge 31
    chk_outs("t1_stable_end", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();                                                       // edge 32 = 14 + 18
    chk_outs("t1_run", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // 5: ext_rst_i held 5 cycles in RUN (edges g1..g5); cnt held at 0 until ext_s clears.
    sif.ext_rst_i = 1'b1;
    tick(2);                                                      // g2
    chk("t5_g2.state", 32'(sif.state_o), 32'd3);
    tick();                                                       // g3
    chk_outs("t5_stable", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(2);                                                      // g5
    sif.ext_rst_i = 1'b0;
    for (int i = 0; i < 17; i++) begin                            // g6..g22
      tick();
      chk("t5_hold.sys_rst", 32'(sif.sys_rst_o), 32'd1);
      chk("t5_hold.pll_rst", 32'(sif.pll_rst_o), 32'd0);
    end
    tick();                                                       // g23
    chk_outs("t5_run", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // 4: lock drops in RUN.
    sif.pll_locked_i = 1'b0;
    tick(2);                                                      // f2
    chk_outs("t4_pre", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();                                                       // f3
    chk_outs("t4_lost", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();                                                       // f4
    chk_outs("t4_after", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(2);                                                      // f6
    chk("t4_f6.pll_rst", 32'(sif.pll_rst_o), 32'd1);
    tick();                                                       // f7
    chk_outs("t4_wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // 3: one-cycle lock glitch seen while STABLE cnt=10.
    sif.pll_locked_i = 1'b1;
    tick(3);                                                      // f10: STABLE cnt 0
    chk("t3_stable.state", 32'(sif.state_o), 32'd2);
    tick(8);                                                      // f18
    sif.pll_locked_i = 1'b0;
    tick();                                                       // f19
    sif.pll_locked_i = 1'b1;
    tick();                                                       // f20: cnt 10
    chk("t3_f20.state", 32'(sif.state_o), 32'd2);
    tick();                                                       // f21
    chk_outs("t3_glitch", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();                                                       // f22
    chk("t3_restable.state", 32'(sif.state_o), 32'd2);
    for (int i = 0; i < 15; i++) begin                            // f23..f37
      tick();
      chk_outs("t3_recount", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    end
    tick();                                                       // f38
    chk_outs("t3_run", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // 2: lock never asserts; three attempts of 36 cycles then FAULT.
    rst_i = 1'b1;
    sif.pll_locked_i = 1'b0;
    tick();                                                       // r0
    chk_outs("t2_reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0;
    for (int k = 1; k < 108; k++) begin
      tick();
      chk("t2_pll_rst", 32'(sif.pll_rst_o), ((k % 36) < 4) ? 32'd1 : 32'd0);
      chk("t2_retries", 32'(sif.retries_o), 32'(k / 36));
      chk("t2_sys_rst", 32'(sif.sys_rst_o), 32'd1);
    end
    tick();                                                       // r108
    chk_outs("t2_fault", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    tick(5);
    chk_outs("t2_fault_hold", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);

    // 6b: ext_rst_i in FAULT is a manual retry.
    sif.ext_rst_i = 1'b1;
    tick(2);                                                      // h2
    chk("t6_h2.fault", 32'(sif.fault_o), 32'd1);
    tick();                                                       // h3
    chk_outs("t6_ext_exit", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    sif.ext_rst_i = 1'b0;
    tick(40);                                                     // h43: second attempt
    chk_outs("t6_retry1", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);

    // 6a: rst_i mid-WAIT_LOCK.
    tick(7);                                                      // h50
    rst_i = 1'b1;
    tick();                                                       // s0
    chk_outs("t6_rst", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_i = 1'b0;
    tick(3);                                                      // s3
    chk("t6_reentry.pll_rst", 32'(sif.pll_rst_o), 32'd1);
    tick();                                                       // s4
    chk_outs("t6_wait", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Lock arriving on the timeout cycle (cnt=31 at s35) wins.
    tick(29);                                                     // s33
    sif.pll_locked_i = 1'b1;
    tick(2);                                                      // s35
    chk("tie_s35.state", 32'(sif.state_o), 32'd1);
    tick();                                                       // s36
    chk_outs("tie_lock_wins", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick(15);                                                     // s51
    chk("tie_s51.state", 32'(sif.state_o), 32'd2);
    tick();                                                       // s52
    chk_outs("tie_run", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

    // Lock loss and ext_rst_i together in RUN: lock loss wins.
    sif.pll_locked_i = 1'b0;
    sif.ext_rst_i    = 1'b1;
    tick(3);                                                      // s55
    chk_outs("both_lockloss_wins", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    sif.ext_rst_i = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
